// File: rtl/fir_div_pkg.sv
// Shared types and constants for the FIR sequential signed divider.
package fir_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam int DEF_DIVIDEND_W = 32;
    localparam int DEF_DIVISOR_W  = 12;

    // Counter must reach DIVIDEND_WIDTH, hence the +1
    localparam int CNT_W = $clog2(DEF_DIVIDEND_W + 1);

    // Saturated quotients at the default dividend width
    localparam logic [DEF_DIVIDEND_W-1:0] SAT_POS = {1'b0, {(DEF_DIVIDEND_W-1){1'b1}}};
    localparam logic [DEF_DIVIDEND_W-1:0] SAT_NEG = {1'b1, {(DEF_DIVIDEND_W-1){1'b0}}};

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fir_optimized_div_32s_12s_seq_step.sv
// One restoring-division step: shift in the next dividend bit, compare
// against the divisor magnitude and conditionally subtract.
module fir_div_step
    import fir_div_pkg::*;
#(
    parameter int DIVISOR_WIDTH = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_WIDTH-1:0] prem_in,
    input  logic                     bit_in,
    input  logic [DIVISOR_WIDTH-1:0] dvs,
    output logic [DIVISOR_WIDTH-1:0] prem_out,
    output logic                     q_bit
);

    logic [DIVISOR_WIDTH:0]   shifted;
    logic [DIVISOR_WIDTH-1:0] diff;

    // Compare/subtract; the difference fits the low bits whenever q_bit is set
    always_comb begin
        shifted  = {prem_in, bit_in};
        diff     = shifted[DIVISOR_WIDTH-1:0] - dvs;
        q_bit    = (shifted >= {1'b0, dvs});
        prem_out = q_bit ? diff : shifted[DIVISOR_WIDTH-1:0];
    end

endmodule

// File: rtl/fir_optimized_div_32s_12s_seq.sv
// Sequential signed divider (restoring, one quotient bit per enabled cycle).
// Optional macro FIR_DIV_ROUND_EN: round the quotient half away from zero and
// return the matching signed remainder; otherwise truncate toward zero.
module fir_optimized_div_32s_12s_seq
    import fir_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_W,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce,
    input  logic                             start,
    input  logic signed [DIVIDEND_WIDTH-1:0] din0,
    input  logic signed [DIVISOR_WIDTH-1:0]  din1,
    output logic                             ready,
    output logic                             done,
    output logic signed [DIVIDEND_WIDTH-1:0] quot,
    output logic signed [DIVISOR_WIDTH-1:0]  rem,
    output logic                             div_zero
);

    localparam int CW = (DIVIDEND_WIDTH == DEF_DIVIDEND_W) ? CNT_W : cnt_width(DIVIDEND_WIDTH);
    localparam logic [DIVIDEND_WIDTH-1:0] QMAX = (DIVIDEND_WIDTH == DEF_DIVIDEND_W)
        ? DIVIDEND_WIDTH'(SAT_POS) : {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
    localparam logic [DIVIDEND_WIDTH-1:0] QMIN = (DIVIDEND_WIDTH == DEF_DIVIDEND_W)
        ? DIVIDEND_WIDTH'(SAT_NEG) : {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [DIVIDEND_WIDTH-1:0] num;     // unsigned magnitude; holds 2^(W-1) exactly
    logic [DIVIDEND_WIDTH-1:0] qmag;
    logic [DIVISOR_WIDTH-1:0]  prem;
    logic [DIVISOR_WIDTH-1:0]  dvs;
    logic                      neg_n, neg_d, dz, ovf;

    logic [DIVISOR_WIDTH-1:0]  step_rem;
    logic                      step_q;

    logic [DIVIDEND_WIDTH-1:0] qm;
    logic signed [DIVISOR_WIDTH:0] rm;
    logic [DIVIDEND_WIDTH-1:0] fix_q;
    logic [DIVISOR_WIDTH-1:0]  fix_r;

    function automatic logic [DIVIDEND_WIDTH-1:0] mag_n(input logic [DIVIDEND_WIDTH-1:0] v);
        return v[DIVIDEND_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DIVISOR_WIDTH-1:0] mag_d(input logic [DIVISOR_WIDTH-1:0] v);
        return v[DIVISOR_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DIVIDEND_WIDTH-1:0] sign_quot(input logic [DIVIDEND_WIDTH-1:0] m,
                                                            input logic neg);
        return neg ? (~m + 1'b1) : m;
    endfunction

    function automatic logic [DIVISOR_WIDTH-1:0] sign_rem(input logic signed [DIVISOR_WIDTH:0] r,
                                                          input logic neg);
        return DIVISOR_WIDTH'(neg ? -r : r);
    endfunction

    // Divide-by-zero result points toward the dividend's sign; -max/-1 clips positive
    function automatic logic [DIVIDEND_WIDTH-1:0] sat_quot(input logic zero, input logic neg);
        return (zero && neg) ? QMIN : QMAX;
    endfunction

`ifdef FIR_DIV_ROUND_EN
    function automatic logic round_up(input logic [DIVISOR_WIDTH-1:0] r,
                                      input logic [DIVISOR_WIDTH-1:0] d);
        return {r, 1'b0} >= {1'b0, d};
    endfunction
`endif

    fir_div_step #(
        .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_step (
        .prem_in  (prem),
        .bit_in   (num[DIVIDEND_WIDTH-1]),
        .dvs      (dvs),
        .prem_out (step_rem),
        .q_bit    (step_q)
    );

    // Sign fix-up, optional rounding and saturation of the finished magnitudes
    always_comb begin
        qm = qmag;
        rm = $signed({1'b0, prem});
`ifdef FIR_DIV_ROUND_EN
        if (round_up(prem, dvs)) begin
            qm = qmag + 1'b1;
            rm = $signed({1'b0, prem}) - $signed({1'b0, dvs});
        end
`endif
        fix_q = sign_quot(qm, neg_n ^ neg_d);
        fix_r = sign_rem(rm, neg_n);
        if (dz || ovf) begin
            fix_q = sat_quot(dz, neg_n);
            fix_r = '0;
        end
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DIVIDEND_WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    quot     <= fix_q;
                    rem      <= fix_r;
                    div_zero <= dz;
                    done     <= 1'b1;
                    ready    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: latch operand magnitudes at acceptance, then one step per CALC edge
    always_ff @(posedge clk) begin
        if (ce) begin
            if (state == IDLE && start) begin
                num   <= mag_n(din0);
                dvs   <= mag_d(din1);
                neg_n <= din0[DIVIDEND_WIDTH-1];
                neg_d <= din1[DIVISOR_WIDTH-1];
                dz    <= (din1 == '0);
                ovf   <= (din0 == QMIN) && (din1 == '1);
                prem  <= '0;
                qmag  <= '0;
            end else if (state == CALC) begin
                prem <= step_rem;
                num  <= {num[DIVIDEND_WIDTH-2:0], 1'b0};
                qmag <= {qmag[DIVIDEND_WIDTH-2:0], step_q};
            end
        end
    end

endmodule
